// File: rtl/prbs_link_test_ctrl.sv
// prbs_link_test_ctrl: PRBS7 loopback bit-error run controller (aligner reset, lock, settle, measure).
// Define PRBS_CTRL_ERR_THRESH_EN to add the err_threshold input and the fail_code 3 early abort.
module prbs_link_test_ctrl #(
    parameter int WINDOW_W      = 32,
    parameter int ERR_W         = 48,
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRY     = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                aligned,
    input  logic [6:0]          err_bits,
`ifdef PRBS_CTRL_ERR_THRESH_EN
    input  logic [ERR_W-1:0]    err_threshold,
`endif
    output logic                align_reset,
    output logic                bypass,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          fail_code,
    output logic [2:0]          state,
    output logic [3:0]          retry_cnt,
    output logic [WINDOW_W-1:0] word_cnt,
    output logic [ERR_W-1:0]    err_bit_cnt,
    output logic [ERR_W-1:0]    err_word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ALIGN_RST = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_MEASURE   = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    // One phase counter is shared by ALIGN_RST, WAIT_LOCK and SETTLE, so size it for the longest.
    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES)
                           ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
                           : ((SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [ERR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

    state_t              state_q;
    state_t              state_next;
    logic [CNT_W-1:0]    phase_cnt;
    logic [WINDOW_W-1:0] window_q;
    logic [WINDOW_W-1:0] word_inc;
    logic [ERR_W-1:0]    err_bit_sum;
    logic [ERR_W-1:0]    err_word_sum;
    logic [1:0]          code_next;
    logic                accept;
    logic                count_en;
    logic                retry_inc;
    logic                retry_req;
    logic                phase_run;
    logic                thresh_hit;

    assign word_inc     = word_cnt + WINDOW_W'(1);
    assign err_bit_sum  = sat_add(err_bit_cnt, ERR_W'(err_bits));
    assign err_word_sum = sat_add(err_word_cnt, ERR_W'(err_bits != 7'd0));

`ifdef PRBS_CTRL_ERR_THRESH_EN
    assign thresh_hit = (err_threshold != '0) && (err_bit_sum > err_threshold);
`else
    assign thresh_hit = 1'b0;
`endif

    assign state     = state_q;
    assign bypass    = 1'b0;
    assign busy      = (state_q == S_ALIGN_RST) || (state_q == S_WAIT_LOCK) ||
                       (state_q == S_SETTLE)    || (state_q == S_MEASURE);
    assign done      = (state_q == S_DONE) || (state_q == S_FAIL);
    assign pass      = (state_q == S_DONE) && (fail_code == 2'd0) && (err_bit_cnt == '0);
    assign phase_run = (state_q == S_ALIGN_RST) || (state_q == S_WAIT_LOCK) ||
                       (state_q == S_SETTLE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        code_next  = fail_code;
        accept     = 1'b0;
        count_en   = 1'b0;
        retry_inc  = 1'b0;
        retry_req  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start && !stop) begin
                    accept     = 1'b1;
                    code_next  = 2'd0;
                    state_next = S_ALIGN_RST;
                end
            end
            S_ALIGN_RST: begin
                if (phase_cnt == RST_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (aligned)                     state_next = S_SETTLE;
                else if (phase_cnt == LOCK_LAST) retry_req  = 1'b1;
            end
            S_SETTLE: begin
                if (!aligned)                      state_next = S_WAIT_LOCK;
                else if (phase_cnt == SETTLE_LAST) state_next = (window_q == '0) ? S_DONE : S_MEASURE;
            end
            S_MEASURE: begin
                // A cycle that loses lock is not counted; the word is measured after realignment.
                if (!aligned) begin
                    retry_req = 1'b1;
                end else begin
                    count_en = 1'b1;
                    if (thresh_hit) begin
                        state_next = S_FAIL;
                        code_next  = 2'd3;
                    end else if (word_inc == window_q) begin
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (retry_req) begin
            if (retry_cnt < RETRY_MAX) begin
                retry_inc  = 1'b1;
                state_next = S_ALIGN_RST;
            end else begin
                state_next = S_FAIL;
                code_next  = 2'd1;
            end
        end

        if (busy && stop) begin
            state_next = S_DONE;
            code_next  = 2'd2;
            count_en   = 1'b0;
            retry_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            align_reset  <= 1'b0;
            fail_code    <= 2'd0;
            phase_cnt    <= '0;
            retry_cnt    <= 4'd0;
            word_cnt     <= '0;
            err_bit_cnt  <= '0;
            err_word_cnt <= '0;
        end else begin
            align_reset <= (state_next == S_ALIGN_RST);
            fail_code   <= code_next;
            if (phase_run && (state_next == state_q)) phase_cnt <= phase_cnt + CNT_W'(1);
            else                                      phase_cnt <= '0;
            if (accept) begin
                retry_cnt    <= 4'd0;
                word_cnt     <= '0;
                err_bit_cnt  <= '0;
                err_word_cnt <= '0;
            end else begin
                if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
                if (count_en) begin
                    word_cnt     <= word_inc;
                    err_bit_cnt  <= err_bit_sum;
                    err_word_cnt <= err_word_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) window_q <= window_len;
    end

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
// Directed bench for prbs_link_test_ctrl: clean, errored, lock-loss, never-lock, abort, reset and zero-window runs.
module tb_prbs_link_test_ctrl;

    localparam int WINDOW_W = 32;
    localparam int ERR_W    = 48;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                stop;
    logic [WINDOW_W-1:0] window_len;
    logic                aligned;
    logic [6:0]          err_bits;
    logic                align_reset;
    logic                bypass;
    logic                busy;
    logic                done;
    logic                pass;
    logic [1:0]          fail_code;
    logic [2:0]          state;
    logic [3:0]          retry_cnt;
    logic [WINDOW_W-1:0] word_cnt;
    logic [ERR_W-1:0]    err_bit_cnt;
    logic [ERR_W-1:0]    err_word_cnt;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ar_pulses   = 0;
    logic ar_prev     = 1'b0;

    prbs_link_test_ctrl #(
        .WINDOW_W     (WINDOW_W),
        .ERR_W        (ERR_W),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (64),
        .SETTLE_CYCLES(16),
        .MAX_RETRY    (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .window_len  (window_len),
        .aligned     (aligned),
        .err_bits    (err_bits),
`ifdef PRBS_CTRL_ERR_THRESH_EN
        .err_threshold('0),
`endif
        .align_reset (align_reset),
        .bypass      (bypass),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .word_cnt    (word_cnt),
        .err_bit_cnt (err_bit_cnt),
        .err_word_cnt(err_word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (align_reset && !ar_prev) ar_pulses++;
        ar_prev = align_reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int n;
        n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 64'(state), 64'(s));
    endtask

    task automatic wait_done(input int limit, input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_state"},     64'(state),        64'd0);
        chk({pfx, "_align_rst"}, 64'(align_reset),  64'd0);
        chk({pfx, "_bypass"},    64'(bypass),       64'd0);
        chk({pfx, "_busy"},      64'(busy),         64'd0);
        chk({pfx, "_done"},      64'(done),         64'd0);
        chk({pfx, "_pass"},      64'(pass),         64'd0);
        chk({pfx, "_fail_code"}, 64'(fail_code),    64'd0);
        chk({pfx, "_retry"},     64'(retry_cnt),    64'd0);
        chk({pfx, "_words"},     64'(word_cnt),     64'd0);
        chk({pfx, "_err_bits"},  64'(err_bit_cnt),  64'd0);
        chk({pfx, "_err_words"}, 64'(err_word_cnt), 64'd0);
    endtask

    task automatic pulse_start(input logic [WINDOW_W-1:0] len);
        window_len = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        int n;
        int w;
        int hi;
        int guard;
        int p0;
        bit dropped;

        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        aligned    = 1'b0;
        err_bits   = 7'd0;
        window_len = '0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Clean link: lock 5 cycles after the aligner reset falls, no bit errors.
        p0 = ar_pulses;
        pulse_start(32'd1000);
        chk("clean_state_after_start", 64'(state), 64'd1);
        hi = 0;
        while (align_reset === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk("clean_align_rst_cycles", 64'(hi), 64'd4);
        chk("clean_wait_lock_state", 64'(state), 64'd2);
        repeat (4) tick();
        aligned = 1'b1;
        wait_done(2000, "clean_done_timeout", n);
        chk("clean_state",     64'(state),       64'd5);
        chk("clean_words",     64'(word_cnt),    64'd1000);
        chk("clean_err_bits",  64'(err_bit_cnt), 64'd0);
        chk("clean_pass",      64'(pass),        64'd1);
        chk("clean_fail_code", 64'(fail_code),   64'd0);
        chk("clean_retry",     64'(retry_cnt),   64'd0);
        chk("clean_busy",      64'(busy),        64'd0);
        chk("clean_pulses",    64'(ar_pulses - p0), 64'd1);

        // Errors on 10 of 100 words, 3 bits each.
        pulse_start(32'd100);
        wait_state(3'd4, 200, "err_reach_measure");
        w = 0;
        guard = 0;
        while (state === 3'd4 && guard < 300) begin
            err_bits = (w % 10 == 5) ? 7'd3 : 7'd0;
            w++;
            tick();
            guard++;
        end
        err_bits = 7'd0;
        chk("err_state",     64'(state),        64'd5);
        chk("err_words",     64'(word_cnt),     64'd100);
        chk("err_bit_cnt",   64'(err_bit_cnt),  64'd30);
        chk("err_word_cnt",  64'(err_word_cnt), 64'd10);
        chk("err_pass",      64'(pass),         64'd0);
        chk("err_fail_code", 64'(fail_code),    64'd0);
        chk("err_done",      64'(done),         64'd1);

        // Lock drops once at word 50 of 200, then relocks.
        p0 = ar_pulses;
        pulse_start(32'd200);
        w = 0;
        dropped = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 3000) begin
            if (state === 3'd4) begin
                if (w == 50 && !dropped) begin
                    aligned = 1'b0;
                    dropped = 1'b1;
                end else begin
                    aligned = 1'b1;
                    w++;
                end
            end else begin
                aligned = 1'b1;
            end
            tick();
            guard++;
        end
        aligned = 1'b1;
        chk("loss_state",     64'(state),          64'd5);
        chk("loss_retry",     64'(retry_cnt),      64'd1);
        chk("loss_pulses",    64'(ar_pulses - p0), 64'd2);
        chk("loss_words",     64'(word_cnt),       64'd200);
        chk("loss_pass",      64'(pass),           64'd1);
        chk("loss_fail_code", 64'(fail_code),      64'd0);

        // Abort at word 30 of 1000; a second start while busy must be ignored.
        pulse_start(32'd1000);
        chk("abort_busy", 64'(busy), 64'd1);
        pulse_start(32'd5);
        wait_state(3'd4, 200, "abort_reach_measure");
        w = 0;
        while (state === 3'd4 && w < 30) begin
            tick();
            w++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_state",     64'(state),     64'd5);
        chk("abort_fail_code", 64'(fail_code), 64'd2);
        chk("abort_words",     64'(word_cnt),  64'd30);
        chk("abort_pass",      64'(pass),      64'd0);
        chk("abort_done",      64'(done),      64'd1);
        chk("abort_busy_low",  64'(busy),      64'd0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_state", 64'(state),     64'd5);
        chk("start_stop_code",  64'(fail_code), 64'd2);

        // Never locks: 8 attempts of 4 reset + 64 timeout cycles each.
        aligned = 1'b0;
        p0 = ar_pulses;
        pulse_start(32'd10);
        wait_done(2000, "nolock_done_timeout", n);
        chk("nolock_cycles",    64'(n),              64'd544);
        chk("nolock_state",     64'(state),          64'd6);
        chk("nolock_fail_code", 64'(fail_code),      64'd1);
        chk("nolock_retry",     64'(retry_cnt),      64'd7);
        chk("nolock_pulses",    64'(ar_pulses - p0), 64'd8);
        chk("nolock_pass",      64'(pass),           64'd0);
        chk("nolock_busy",      64'(busy),           64'd0);

        // Reset in the middle of a measurement.
        aligned = 1'b1;
        pulse_start(32'd1000);
        wait_state(3'd4, 200, "rst_reach_measure");
        err_bits = 7'd1;
        repeat (5) tick();
        err_bits = 7'd0;
        chk("rst_pre_err_bits", 64'(err_bit_cnt), 64'd5);
        reset = 1'b1;
        tick();
        check_idle("midrst");
        reset = 1'b0;
        tick();

        // Zero-length window finishes straight after settle.
        pulse_start(32'd0);
        wait_done(200, "zero_done_timeout", n);
        chk("zero_cycles",    64'(n),         64'd21);
        chk("zero_state",     64'(state),     64'd5);
        chk("zero_words",     64'(word_cnt),  64'd0);
        chk("zero_pass",      64'(pass),      64'd1);
        chk("zero_fail_code", 64'(fail_code), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
